// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ burst requesters.
// Optional FIFO_ARB_STATS_EN adds a saturating accepted-word counter on wr_count.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
`ifdef FIFO_ARB_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                          w_clk,
  input  logic                          w_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  , output logic [CNT_WIDTH-1:0]        wr_count
`endif
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [GW-1:0] sel;
  logic          sel_found;
`ifdef FIFO_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;
`endif

  // NOTE: reset is synchronous, so it only takes effect on a w_clk edge; all state uses <=.
  always_ff @(posedge w_clk) begin
    if (!w_rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= GW'(NUM_REQ - 1);
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
`ifdef FIFO_ARB_STATS_EN
      wr_count_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
`ifdef FIFO_ARB_STATS_EN
      wr_count_q  <= wr_count_d;
`endif
    end
  end

  // Rotating priority scan starting just after the last winner.
  always_comb begin
    int idx;
    sel       = '0;
    sel_found = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel       = GW'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
`ifdef FIFO_ARB_STATS_EN
    wr_count_d  = wr_count_q;
    if (winc && (wr_count_q != '1)) wr_count_d = wr_count_q + 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d     = BURST;
          grant_id_d  = sel;
          rr_ptr_d    = sel;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (winc) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (req_last[grant_id_q] || (burst_cnt_q == BW'(MAX_BURST - 1))) state_d = IDLE;
        end else if (!req_valid[grant_id_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO stalls the granted requester without counting as a bubble.
  always_comb begin
    req_ready = '0;
    winc      = 1'b0;
    wdata     = '0;
    if (state_q == BURST) begin
      req_ready[grant_id_q] = ~wfull;
      winc                  = req_valid[grant_id_q] & ~wfull;
      if (winc) wdata = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == BURST);
`ifdef FIFO_ARB_STATS_EN
  assign wr_count = wr_count_q;
`endif

endmodule
